// File: rtl/func_sq_cbrt.sv
// func_sq_cbrt: computes y = a*a + cbrt(b). It runs the cbrt unit first and lends it the
// shared multiplier, then takes the multiplier back to square a. FUNC_TIMEOUT_EN adds a wait-state timeout.
module func_sq_cbrt
`ifdef FUNC_TIMEOUT_EN
  #(parameter logic [7:0] TIMEOUT = 8'd255)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  a_bi,
  input  logic [7:0]  b_bi,
  input  logic        start_i,
  output logic        busy_o,
  output logic [15:0] y_bo,
  output logic        err_o,
  output logic [7:0]  cb_x_bo,
  output logic        cb_start_o,
  input  logic        cb_busy_i,
  input  logic [2:0]  cb_y_bi,
  input  logic [7:0]  cb_mul_a_bi,
  input  logic [7:0]  cb_mul_b_bi,
  input  logic        cb_mul_start_i,
  output logic        cb_mul_busy_o,
  output logic [15:0] cb_mul_y_bo,
  output logic [7:0]  mul_a_bo,
  output logic [7:0]  mul_b_bo,
  output logic        mul_start_o,
  input  logic        mul_busy_i,
  input  logic [15:0] mul_y_bi
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_GO   = 3'd1,
    C_WAIT = 3'd2,
    M_GO   = 3'd3,
    M_WAIT = 3'd4,
    ADD    = 3'd5
  } state_t;

  state_t      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  c_q;
  logic [15:0] p_q;
  logic [15:0] y_q;
  logic        busy_q;
  logic        cb_start_q;
  logic        seen_q;
  logic [7:0]  mul_a_s;
  logic [7:0]  mul_b_s;
  logic        mul_start_s;

`ifdef FUNC_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  logic       tmo_s;
  assign tmo_s = (cnt_q == (TIMEOUT - 8'd1));
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o        = busy_q;
  assign y_bo          = y_q;
  assign cb_x_bo       = b_q;
  assign cb_start_o    = cb_start_q;
  assign cb_mul_busy_o = mul_busy_i;
  assign cb_mul_y_bo   = mul_y_bi;
  assign mul_a_bo      = mul_a_s;
  assign mul_b_bo      = mul_b_s;
  assign mul_start_o   = mul_start_s;

  // Sequencer FSM with registered handshake outputs; a WAIT state ends once busy was seen high then low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      c_q        <= 3'd0;
      p_q        <= 16'd0;
      y_q        <= 16'd0;
      busy_q     <= 1'b0;
      cb_start_q <= 1'b0;
      seen_q     <= 1'b0;
`ifdef FUNC_TIMEOUT_EN
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      cb_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q        <= a_bi;
            b_q        <= b_bi;
            busy_q     <= 1'b1;
            cb_start_q <= 1'b1;
            state_q    <= C_GO;
`ifdef FUNC_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        C_GO: begin
          seen_q  <= 1'b0;
          state_q <= C_WAIT;
`ifdef FUNC_TIMEOUT_EN
          cnt_q   <= 8'd0;
`endif
        end
        C_WAIT: begin
          if (seen_q && !cb_busy_i) begin
            c_q     <= cb_y_bi;
            state_q <= M_GO;
          end
`ifdef FUNC_TIMEOUT_EN
          else if (tmo_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            y_q     <= 16'd0;
            err_q   <= 1'b1;
          end
`endif
          else begin
            seen_q <= seen_q | cb_busy_i;
`ifdef FUNC_TIMEOUT_EN
            cnt_q  <= cnt_q + 8'd1;
`endif
          end
        end
        M_GO: begin
          seen_q  <= 1'b0;
          state_q <= M_WAIT;
`ifdef FUNC_TIMEOUT_EN
          cnt_q   <= 8'd0;
`endif
        end
        M_WAIT: begin
          if (seen_q && !mul_busy_i) begin
            p_q     <= mul_y_bi;
            state_q <= ADD;
          end
`ifdef FUNC_TIMEOUT_EN
          else if (tmo_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            y_q     <= 16'd0;
            err_q   <= 1'b1;
          end
`endif
          else begin
            seen_q <= seen_q | mul_busy_i;
`ifdef FUNC_TIMEOUT_EN
            cnt_q  <= cnt_q + 8'd1;
`endif
          end
        end
        ADD: begin
          y_q     <= p_q + {13'd0, c_q};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Multiplier ownership: cbrt drives it during its phase, otherwise it squares a.
  always_comb begin
    mul_a_s     = a_q;
    mul_b_s     = a_q;
    mul_start_s = 1'b0;
    case (state_q)
      C_GO, C_WAIT: begin
        mul_a_s     = cb_mul_a_bi;
        mul_b_s     = cb_mul_b_bi;
        mul_start_s = cb_mul_start_i;
      end
      M_GO: begin
        mul_start_s = 1'b1;
      end
      default: begin
        mul_start_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_func_sq_cbrt.sv
// Bench for func_sq_cbrt: behavioural cbrt and multiplier stand-ins with per-run busy lengths,
// table-driven result/latency vectors plus reset, ignored-start, mux and (with FUNC_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_func_sq_cbrt;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  a_bi = 8'd0;
  logic [7:0]  b_bi = 8'd0;
  logic        start_i = 1'b0;
  logic        busy_o;
  logic [15:0] y_bo;
  logic        err_o;
  logic [7:0]  cb_x_bo;
  logic        cb_start_o;
  logic        cb_busy_i;
  logic [2:0]  cb_y_bi;
  logic [7:0]  cb_mul_a_bi = 8'd0;
  logic [7:0]  cb_mul_b_bi = 8'd0;
  logic        cb_mul_start_i = 1'b0;
  logic        cb_mul_busy_o;
  logic [15:0] cb_mul_y_bo;
  logic [7:0]  mul_a_bo;
  logic [7:0]  mul_b_bo;
  logic        mul_start_o;
  logic        mul_busy_i;
  logic [15:0] mul_y_bi;

  int checks = 0;
  int errors = 0;
  int tc_v = 1;
  int tm_v = 1;
  logic hold_mul = 1'b0;

  always #5 clk_i = ~clk_i;

`ifdef FUNC_TIMEOUT_EN
  func_sq_cbrt #(.TIMEOUT(8'd20)) dut (
`else
  func_sq_cbrt dut (
`endif
    .clk_i(clk_i), .rst_i(rst_i), .a_bi(a_bi), .b_bi(b_bi), .start_i(start_i),
    .busy_o(busy_o), .y_bo(y_bo), .err_o(err_o),
    .cb_x_bo(cb_x_bo), .cb_start_o(cb_start_o), .cb_busy_i(cb_busy_i), .cb_y_bi(cb_y_bi),
    .cb_mul_a_bi(cb_mul_a_bi), .cb_mul_b_bi(cb_mul_b_bi), .cb_mul_start_i(cb_mul_start_i),
    .cb_mul_busy_o(cb_mul_busy_o), .cb_mul_y_bo(cb_mul_y_bo),
    .mul_a_bo(mul_a_bo), .mul_b_bo(mul_b_bo), .mul_start_o(mul_start_o),
    .mul_busy_i(mul_busy_i), .mul_y_bi(mul_y_bi)
  );

  function automatic logic [2:0] icbrt(input logic [7:0] x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= int'(x)) r++;
    return 3'(r);
  endfunction

  // cbrt stand-in: busy for tc_v cycles after a sampled start
  logic cb_busy_q;
  int   cb_cnt;
  assign cb_busy_i = cb_busy_q;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cb_busy_q <= 1'b0; cb_cnt <= 0; cb_y_bi <= 3'd0;
    end else if (cb_busy_q) begin
      if (cb_cnt == 1) cb_busy_q <= 1'b0;
      cb_cnt <= cb_cnt - 1;
    end else if (cb_start_o) begin
      cb_busy_q <= 1'b1; cb_cnt <= tc_v; cb_y_bi <= icbrt(cb_x_bo);
    end
  end

  // multiplier stand-in: busy for tm_v cycles after a sampled start
  logic mul_busy_q;
  int   mul_cnt;
  assign mul_busy_i = mul_busy_q | hold_mul;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mul_busy_q <= 1'b0; mul_cnt <= 0; mul_y_bi <= 16'd0;
    end else if (mul_busy_q) begin
      if (mul_cnt == 1) mul_busy_q <= 1'b0;
      mul_cnt <= mul_cnt - 1;
    end else if (mul_start_o) begin
      mul_busy_q <= 1'b1; mul_cnt <= tm_v; mul_y_bi <= 16'(mul_a_bo * mul_b_bo);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input int c, input int m);
    @(negedge clk_i);
    tc_v = c; tm_v = m; a_bi = a; b_bi = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("busy_after_accept", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (busy_o && lat < 300) begin
      @(posedge clk_i); #1;
      lat++;
    end
    if (lat >= 300) begin
      errors++;
      $display("FAIL busy_timeout: busy_o still high after %0d cycles", lat);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          tc;
    int          tm;
    logic [15:0] y;
    int          lat;
  } vec_t;

  vec_t v[6];
  int lat;
  int n;

  initial begin
    v[0] = '{8'd0,   8'd0,   3, 2, 16'd0,     10};
    v[1] = '{8'd255, 8'd255, 4, 3, 16'd65031, 12};
    v[2] = '{8'd3,   8'd64,  2, 2, 16'd13,    9};
    v[3] = '{8'd2,   8'd27,  1, 1, 16'd7,     7};
    v[4] = '{8'd10,  8'd8,   5, 4, 16'd102,   14};
    v[5] = '{8'd16,  8'd1,   2, 3, 16'd257,   10};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_y", 32'(y_bo), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_cb_x", 32'(cb_x_bo), 32'd0);
    check("rst_cb_start", 32'(cb_start_o), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_op(v[i].a, v[i].b, v[i].tc, v[i].tm);
      wait_done(lat);
      check("vec_latency", 32'(lat), 32'(v[i].lat));
      check("vec_y", 32'(y_bo), 32'(v[i].y));
      check("vec_err", 32'(err_o), 32'd0);
    end
    repeat (3) @(posedge clk_i);
    #1;
    check("y_hold", 32'(y_bo), 32'd257);

    // start while busy is ignored
    start_op(8'd3, 8'd64, 3, 2);
    repeat (2) begin @(posedge clk_i); #1; end
    a_bi = 8'd9; b_bi = 8'd8; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("ignore_cb_x", 32'(cb_x_bo), 32'd64);
    wait_done(lat);
    check("ignore_y", 32'(y_bo), 32'd13);

    // reset during C_WAIT, then a fresh request
    start_op(8'd7, 8'd200, 10, 2);
    repeat (3) begin @(posedge clk_i); #1; end
    @(negedge clk_i) rst_i = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_y", 32'(y_bo), 32'd0);
    check("midrst_cb_x", 32'(cb_x_bo), 32'd0);
    @(negedge clk_i) rst_i = 1'b1;
    start_op(8'd2, 8'd27, 2, 2);
    wait_done(lat);
    check("after_rst_y", 32'(y_bo), 32'd7);

    // idle: cbrt's multiplier request must not pass through
    @(negedge clk_i);
    cb_mul_start_i = 1'b1; cb_mul_a_bi = 8'h11; cb_mul_b_bi = 8'h22;
    #1;
    check("idle_mul_start", 32'(mul_start_o), 32'd0);
    check("idle_mul_a", 32'(mul_a_bo), 32'd2);
    @(negedge clk_i) cb_mul_start_i = 1'b0;
    #1;
    check("pass_busy", 32'(cb_mul_busy_o), 32'(mul_busy_i));
    check("pass_y", 32'(cb_mul_y_bo), 32'(mul_y_bi));
    repeat (4) @(posedge clk_i);

    // mux follows cbrt during its phase, then squares a
    start_op(8'd5, 8'd100, 8, 2);
    check("cb_start_pulse", 32'(cb_start_o), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i); #1;
      cb_mul_start_i = (k == 1 || k == 4);
      cb_mul_a_bi = 8'(8'h50 + k);
      cb_mul_b_bi = 8'(8'hA0 + k);
      #1;
      if (k == 1) check("cb_start_one_cycle", 32'(cb_start_o), 32'd0);
      check("mux_start", 32'(mul_start_o), 32'(cb_mul_start_i));
      check("mux_a", 32'(mul_a_bo), 32'(cb_mul_a_bi));
      check("mux_b", 32'(mul_b_bo), 32'(cb_mul_b_bi));
    end
    cb_mul_start_i = 1'b0;
    n = 0;
    while (!mul_start_o && n < 50) begin @(posedge clk_i); #1; n++; end
    check("mgo_start", 32'(mul_start_o), 32'd1);
    check("mgo_a", 32'(mul_a_bo), 32'd5);
    check("mgo_b", 32'(mul_b_bo), 32'd5);
    wait_done(lat);
    check("mux_y", 32'(y_bo), 32'd29);

`ifdef FUNC_TIMEOUT_EN
    hold_mul = 1'b1;
    start_op(8'd4, 8'd8, 2, 2);
    wait_done(lat);
    check("tmo_latency", 32'(lat), 32'd25);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_y", 32'(y_bo), 32'd0);
    hold_mul = 1'b0;
    repeat (4) @(posedge clk_i);
    start_op(8'd1, 8'd1, 1, 1);
    check("tmo_err_clear", 32'(err_o), 32'd0);
    wait_done(lat);
    check("tmo_next_y", 32'(y_bo), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/func_sq_cbrt.md
# func_sq_cbrt

Sequencer that computes y = a² + ∛b on 8-bit unsigned operands. It sits directly upstream of the `cbrt` unit and shares the single `mult` instance with it. The block launches `cbrt` on b while routing the multiplier to `cbrt`, then takes the multiplier back to square a, and adds the two results. The external start/busy handshake has the same shape as `mult` and `cbrt`, so the block can itself be driven by a higher-level controller.

## Interface
- TIMEOUT, 255: max cycles allowed in any wait state; used only with `FUNC_TIMEOUT_EN`.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- a_bi  in  8  operand a (squared)
- b_bi  in  8  operand b (cube-rooted)
- start_i  in  1  request; accepted only in IDLE
- busy_o  out  1  high from the cycle after acceptance until the result is written
- y_bo  out  16  result; valid when busy_o is low
- err_o  out  1  timeout flag; always 0 unless `FUNC_TIMEOUT_EN`
- cb_x_bo  out  8  operand to cbrt (latched b)
- cb_start_o  out  1  start pulse to cbrt
- cb_busy_i  in  1  cbrt busy
- cb_y_bi  in  3  cbrt result
- cb_mul_a_bi  in  8  cbrt's multiplier operand a
- cb_mul_b_bi  in  8  cbrt's multiplier operand b
- cb_mul_start_i  in  1  cbrt's multiplier start
- cb_mul_busy_o  out  1  pass-through of mul_busy_i
- cb_mul_y_bo  out  16  pass-through of mul_y_bi
- mul_a_bo  out  8  multiplier operand a
- mul_b_bo  out  8  multiplier operand b
- mul_start_o  out  1  multiplier start
- mul_busy_i  in  1  multiplier busy
- mul_y_bi  in  16  multiplier product

## Operation
- States: IDLE, C_GO, C_WAIT, M_GO, M_WAIT, ADD.
- IDLE, start_i=1: latch a_bi→a_r and b_bi→b_r, set busy_o, clear err_o, go to C_GO. With start_i=0 in IDLE, nothing changes.
- C_GO: cb_start_o=1 for exactly one cycle, cb_x_bo=b_r; go to C_WAIT.
- C_WAIT: wait until cb_busy_i has been seen high and then reads low. On that cycle latch cb_y_bi→c_r and go to M_GO.
- M_GO: mul_a_bo=mul_b_bo=a_r, mul_start_o=1 for one cycle; go to M_WAIT.
- M_WAIT: wait until mul_busy_i has been seen high and then reads low. On that cycle latch mul_y_bi→p_r and go to ADD.
- ADD: y_bo <= p_r + {13'b0,c_r}, busy_o <= 0, go to IDLE.
- Arithmetic: the maximum sum is 65025+6 = 65031, which fits in 16 bits; there is no overflow handling.
- Multiplier mux, combinational:
  - In C_GO and C_WAIT, mul_a_bo/mul_b_bo/mul_start_o = cb_mul_a_bi/cb_mul_b_bi/cb_mul_start_i.
  - In M_GO, drive as above (a_r, a_r, start=1).
  - In all other states, drive a_r, a_r, 0.
  - cb_mul_busy_o and cb_mul_y_bo are pure pass-throughs in every state.
- start_i while busy_o=1 is ignored; latched operands do not change.
- Reset, including mid-operation: state=IDLE, busy_o=0, y_bo=0, err_o=0, cb_x_bo=0, cb_start_o=0, all internal registers 0. Sub-units are reset by the same rst_i.

## Timing
- Acceptance: start_i is sampled at edge N; busy_o=1 from edge N.
- cb_start_o is high during the cycle after edge N.
- Total latency from the accepting edge to busy_o falling = Tc + Tm + 5 cycles:
  - Tc = cycles cb_busy_i is high; Tm = cycles mul_busy_i is high.
  - The 5 cycles of overhead are the edges into C_GO, C_WAIT, M_GO, M_WAIT and ADD.
- y_bo and busy_o update on the same edge (leaving ADD). y_bo holds until the next ADD, or until a timeout or reset.
- The seen-high flags reset on entering each WAIT state. A sub-unit whose busy rises late is tolerated.

## Configuration
- Macro: `FUNC_TIMEOUT_EN`.
- Defined:
  - An 8-bit wait counter clears on entering C_WAIT or M_WAIT and increments every cycle in those states.
  - On reaching TIMEOUT: go to IDLE, busy_o=0, y_bo=0, err_o=1.
  - err_o stays high until the next accepted start_i or reset.
- Undefined: no counter is built, err_o is tied to 0, and the WAIT states may wait indefinitely.

## Test plan
- a=0, b=0, start pulse → busy_o falls after Tc+Tm+5 cycles; y_bo=0, err_o=0.
- a=255, b=255 → y_bo=65031.
- a=3, b=64 → y_bo=13. While busy, pulse start_i with a=9, b=8 → ignored; y_bo still 13.
- Reset asserted (low) during C_WAIT → busy_o=0, y_bo=0 immediately. A new request a=2, b=27 afterwards → y_bo=7.
- Mux check during the cbrt phase: mul_start_o must track cb_mul_start_i exactly. During M_GO, mul_a_bo=mul_b_bo=a.
- With `FUNC_TIMEOUT_EN` and TIMEOUT=20: the bench holds mul_busy_i=1 → after 20 cycles in a wait state, busy_o=0, err_o=1, y_bo=0. The next start_i clears err_o.
